// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the arbitrated 8N1 transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int calc_divider(input int clk_freq, input int baud);
        return clk_freq / baud - 1;
    endfunction

    function automatic int cnt_width(input int divider);
        return (divider < 1) ? 1 : $clog2(divider + 1);
    endfunction

    localparam int DEFAULT_DIVIDER = calc_divider(50000000, 38400);
    localparam int CNT_W           = cnt_width(DEFAULT_DIVIDER);

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter; tick marks the last clock of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIVIDER = DEFAULT_DIVIDER,
    parameter int CNT_W   = cnt_width(DIVIDER)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIVIDER);

    logic [CNT_W-1:0] count;

    assign tick = (count == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbitration of two byte sources onto one 8N1 line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 38400,
    parameter int DIVIDER  = calc_divider(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int             CW       = cnt_width(DIVIDER);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t state, state_nx;
    logic [7:0]  shift, shift_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic        tx_nx, busy_nx, grant_nx;
    logic        last_grant, last_nx;
    logic        sel, accept, tick;

    // Contended cycles go to whoever did not win last; reset leaves last=1 so req0 wins first.
    assign sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !sel;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  sel;
    assign accept     = req0_ready || req1_ready;

    // Holding the counter cleared while idle aligns every bit period to the accept edge.
    uart_baud_tick #(
        .DIVIDER (DIVIDER),
        .CNT_W   (CW)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept || !busy),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            bit_idx    <= bit_idx_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            grant_id   <= grant_nx;
            last_grant <= last_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_idx_nx = bit_idx;
        tx_nx      = tx;
        busy_nx    = busy;
        grant_nx   = grant_id;
        last_nx    = last_grant;

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (accept) begin
                    shift_nx = sel ? req1_data : req0_data;
                    grant_nx = sel;
                    last_nx  = sel;
                    state_nx = START;
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_nx   = DATA;
                    tx_nx      = shift[0];
                    bit_idx_nx = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx != LAST_BIT) begin
                        // shift[1] is the bit that lands in shift[0] after this edge.
                        shift_nx   = shift >> 1;
                        tx_nx      = shift[1];
                        bit_idx_nx = bit_idx + 3'd1;
                    end else begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    tx_nx    = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench with a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int CLK_FREQ   = 50000000;
    localparam int BAUD       = 2500000;
    localparam int BIT        = CLK_FREQ / BAUD;
    localparam int FRAME_CLKS = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready, tx, busy, grant_id;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    uart_tx_arbiter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a countdown of FRAME_CLKS clocks after each accept.
    typedef struct {
        logic       g;
        logic [7:0] b;
        int         gap;
    } ent_t;

    ent_t       m_log[$];
    int         m_left, m_idle;
    logic       m_last, m_grant;
    logic [7:0] m_byte;
    logic       e_sel, e_rdy0, e_rdy1, e_tx;
    int         e_bit;

    always_comb begin
        e_sel = 1'b0;
        if (req0_valid && req1_valid) e_sel = ~m_last;
        else if (req1_valid)          e_sel = 1'b1;
        e_rdy0 = rst_n && (m_left == 0) && req0_valid && !e_sel;
        e_rdy1 = rst_n && (m_left == 0) && req1_valid &&  e_sel;
        e_bit  = 0;
        e_tx   = 1'b1;
        if (m_left != 0) begin
            e_bit = (FRAME_CLKS - m_left) / BIT;
            if (e_bit == 0)      e_tx = 1'b0;
            else if (e_bit <= 8) e_tx = m_byte[e_bit-1];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_idle  <= 0;
            m_last  <= 1'b1;
            m_grant <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
        end else if (e_rdy0 || e_rdy1) begin
            m_left  <= FRAME_CLKS;
            m_grant <= e_rdy1;
            m_last  <= e_rdy1;
            m_byte  <= e_rdy1 ? req1_data : req0_data;
            m_idle  <= 0;
            m_log.push_back('{g: e_rdy1, b: (e_rdy1 ? req1_data : req0_data), gap: m_idle + 1});
        end else begin
            m_idle <= m_idle + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on)
            check("cycle_outs", {27'd0, req0_ready, req1_ready, busy, tx, grant_id},
                  {27'd0, e_rdy0, e_rdy1, (m_left != 0), e_tx, m_grant});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic wait_log(input string tag, input int target, input int bound);
        int k = 0;
        while (m_log.size() < target && k < bound) begin
            cyc(1);
            k++;
        end
        check(tag, 32'(m_log.size() >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (m_left != 0 && k < 2 * FRAME_CLKS) begin
            cyc(1);
            k++;
        end
        check(tag, 32'(m_left == 0), 32'd1);
        cyc(1);
    endtask

    // Samples the line from the first clock after an accept edge.
    task automatic capture_frame(output int low_len, output int busy_len, output logic [7:0] b);
        logic smp [FRAME_CLKS + 4];
        low_len  = 0;
        busy_len = 0;
        for (int k = 0; k < FRAME_CLKS + 4; k++) begin
            @(negedge clk);
            smp[k] = tx;
            if (busy) busy_len++;
        end
        while (low_len < FRAME_CLKS && smp[low_len] == 1'b0) low_len++;
        for (int j = 0; j < 8; j++) b[j] = smp[(j + 1) * BIT + BIT / 2];
        #1;
    endtask

    int         low_len, busy_len, base;
    logic [7:0] got_b;

    initial begin
        cyc(1);
        chk_on = 1'b1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant", 32'(grant_id), 32'd0);
        req0_valid = 1'b1;
        #1;
        check("reset_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // Single byte from req0
        req0_data  = 8'hA5;
        req0_valid = 1'b1;
        #1;
        check("t1_ready0", 32'({req0_ready, req1_ready}), 32'd2);
        cyc(1);
        req0_valid = 1'b0;
        capture_frame(low_len, busy_len, got_b);
        check("t1_start_len", 32'(low_len), 32'(BIT));
        check("t1_busy_len", 32'(busy_len), 32'(FRAME_CLKS));
        check("t1_byte", 32'(got_b), 32'hA5);
        check("t1_grant", 32'(grant_id), 32'd0);

        // Both continuously valid from fresh reset: strict alternation from req0
        do_reset();
        base = m_log.size();
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_log("t2_timeout", base + 4, 6 * FRAME_CLKS);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("t2_idle");
        for (int i = 0; i < 4; i++) begin
            if (m_log.size() > base + i) begin
                check("t2_grant", 32'(m_log[base+i].g), 32'(i % 2));
                check("t2_byte", 32'(m_log[base+i].b), (i % 2) ? 32'h22 : 32'h11);
                if (i > 0) check("t2_gap", 32'(m_log[base+i].gap), 32'd1);
            end
        end

        // req1 alone with all-zero data
        req1_data  = 8'h00;
        req1_valid = 1'b1;
        cyc(1);
        req1_valid = 1'b0;
        capture_frame(low_len, busy_len, got_b);
        check("t3_low_len", 32'(low_len), 32'(9 * BIT));
        check("t3_grant", 32'(grant_id), 32'd1);
        cyc(2);

        // req0 arrives during a req1 frame and waits for IDLE
        req1_data  = 8'h5A;
        req1_valid = 1'b1;
        cyc(1);
        req1_valid = 1'b0;
        cyc(30);
        base = m_log.size();
        req0_data  = 8'h3C;
        req0_valid = 1'b1;
        #1;
        check("t4_ready0_busy", 32'(req0_ready), 32'd0);
        wait_log("t4_timeout", base + 1, 2 * FRAME_CLKS);
        req0_valid = 1'b0;
        if (m_log.size() > base) begin
            check("t4_grant", 32'(m_log[base].g), 32'd0);
            check("t4_byte", 32'(m_log[base].b), 32'h3C);
            check("t4_gap", 32'(m_log[base].gap), 32'd1);
        end
        wait_idle("t4_idle");

        // Reset in the middle of a frame
        req0_data  = 8'hFF;
        req0_valid = 1'b1;
        cyc(1);
        req0_valid = 1'b0;
        cyc(5 * BIT);
        rst_n = 1'b0;
        #1;
        check("t5_tx_reset", 32'(tx), 32'd1);
        check("t5_busy_reset", 32'(busy), 32'd0);
        req0_data = 8'h96; req1_data = 8'h69;
        req0_valid = 1'b1; req1_valid = 1'b1;
        cyc(2);
        base = m_log.size();
        rst_n = 1'b1;
        wait_log("t5_timeout", base + 1, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (m_log.size() > base) begin
            check("t5_first_grant", 32'(m_log[base].g), 32'd0);
            check("t5_byte", 32'(m_log[base].b), 32'h96);
        end
        wait_idle("t5_idle");

        // One-cycle req0 pulse while busy is never served
        req1_data  = 8'h81;
        req1_valid = 1'b1;
        cyc(1);
        req1_valid = 1'b0;
        cyc(40);
        base = m_log.size();
        req0_data  = 8'h77;
        req0_valid = 1'b1;
        cyc(1);
        req0_valid = 1'b0;
        wait_idle("t6_idle");
        cyc(3 * FRAME_CLKS);
        check("t6_no_frame", 32'(m_log.size()), 32'(base));
        check("t6_line_idle", 32'({tx, busy}), 32'd2);

        // Randomised traffic, including occasional resets
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) req0_valid = ~req0_valid;
            if ($urandom_range(0, 15) == 0) req1_valid = ~req1_valid;
            req0_data = 8'($urandom);
            req1_data = 8'($urandom);
            if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
            else                              rst_n = 1'b1;
            cyc(1);
        end
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("rand_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmit line between two byte requesters using round-robin arbitration. It generates the bit timing internally from the system clock, then serialises each granted byte as start, 8 data bits (LSB first) and stop. It sits between producer logic, such as a status reporter and a debug dumper, and the board tx pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz.
BAUD, 38400, line rate in bit/s.
DIVIDER, CLK_FREQ/BAUD-1 (=1301), terminal count of the bit-period counter. One bit lasts DIVIDER+1 clocks.

Ports:
clk  in  1  system clock, 50 MHz, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has a byte.
req0_data  in  8  requester 0 byte.
req0_ready  out  1  requester 0 byte accepted this cycle when valid is also high.
req1_valid  in  1  requester 1 has a byte.
req1_data  in  8  requester 1 byte.
req1_ready  out  1  requester 1 byte accepted this cycle when valid is also high.
tx  out  1  UART line, idle high, registered.
busy  out  1  frame in progress (state != IDLE), registered.
grant_id  out  1  requester whose byte is or was last on the line, registered.

Behaviour:
- Reset values (rst_n low, asynchronous): tx=1, busy=0, grant_id=0, state=IDLE, bit counter=0, bit index=0, last_grant=1. req*_ready=0 while rst_n is low.
- States: IDLE, START, DATA, STOP. Encoding comes from the package.
- IDLE:
  - tx=1.
  - Arbiter selects a requester. If only one valid is high, select it. If both are high, select the one != last_grant.
  - reqN_ready is combinational: high only in IDLE, only for the selected requester, and only when that requester's valid is high. The other ready stays 0.
- Accept on the edge where valid&&ready:
  - Capture data into a shift register.
  - grant_id<=N, last_grant<=N, state<=START, tx<=0, busy<=1, bit counter<=0.
  - Latency: tx falls on the first edge after acceptance.
- Bit timing:
  - Counter increments every clock while busy. tick = (counter==DIVIDER); on tick the counter wraps to 0.
  - Each line level therefore holds exactly DIVIDER+1 clocks.
- START: on tick go to DATA with tx<=shift[0] and bit index=0.
- DATA:
  - On tick, if index<7: shift right, tx<=next bit, index+1.
  - If index==7: go to STOP with tx<=1.
- STOP: on tick go to IDLE with busy<=0 and tx stays 1.
- Frame length is 10*(DIVIDER+1) = 13020 clocks from the tx falling edge to busy deasserting.
- Back-to-back: IDLE lasts at least one cycle, so the next start bit begins no earlier than 1 clock after the stop bit ends.
- Requester rules: valid may drop without a handshake; no byte is consumed. Data need only be stable in the accept cycle. Requests arriving while busy wait; ready stays 0.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… The first grant after reset goes to req0.
- Reset mid-frame: tx returns to 1 immediately, the frame is truncated, the captured byte is discarded, and arbitration restarts with req0 priority.
- Counter width is clog2(DIVIDER+1) bits (11 for the defaults). The counter never exceeds DIVIDER.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - FRAME_BITS=10;
  - a function computing DIVIDER from CLK_FREQ/BAUD;
  - the counter-width constant.
- Sub-module uart_baud_tick (clk, rst_n, clear, tick) contains the bit-period counter. clear is asserted on accept.
- Arbiter and FSM stay in uart_tx_arbiter.

Test Plan:
- Reset, then req0_valid=1 with data 8'hA5 → req0_ready=1 in the same cycle. tx low for 1302 clocks, then bits 1,0,1,0,0,1,0,1 of 1302 clocks each, then stop high. busy falls 13020 clocks after tx falls. grant_id=0.
- Both valid continuously, req0=8'h11, req1=8'h22 → frames decode 11,22,11,22. ready never high on both requesters in one cycle. Inter-frame idle ≥1 clock.
- req1 valid alone with 8'h00 → tx low for 9*1302 clocks, then high. grant_id=1.
- req0 asserts valid during a req1 frame → req0_ready stays 0 until IDLE, then the 8'h3C frame starts 1 clock after busy falls.
- rst_n pulsed low mid-DATA of 8'hFF → tx=1 within the reset, busy=0. After release, req1 and req0 both valid → req0 granted first.
- req0_valid pulsed for 1 cycle while busy then dropped → no frame is sent for it. The line stays idle high after the current frame.
